// File: rtl/req_arbiter_pkg.sv
// Shared types for the requestor arbiter: node id width, FSM states and
// drop-counter width. node_id_t matches the chiplet-wide definition.
package req_arbiter_pkg;

    localparam int unsigned NODE_ID_W  = 5;
    localparam int unsigned DROP_CNT_W = 16;

    typedef logic [NODE_ID_W-1:0] node_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/req_arbiter_if.sv
// Bus between the per-link CRC receive paths, the arbiter and the requestor
// FIFO write port, plus the software-visible status.
interface req_arbiter_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned CNT_W     = 5
);
    import req_arbiter_pkg::*;

    logic                           enable;
    logic                           flush;
    logic [NUM_PORTS-1:0]           req_valid;
    logic [NUM_PORTS*NODE_ID_W-1:0] req_id;
    logic [CNT_W-1:0]               fifo_count;
    logic                           fifo_wen;
    node_id_t                       fifo_wdata;
    logic [NUM_PORTS-1:0]           held;
    logic [DROP_CNT_W-1:0]          drop_count;
    logic                           busy;

    modport slave (
        input  enable, flush, req_valid, req_id, fifo_count,
        output fifo_wen, fifo_wdata, held, drop_count, busy
    );

    modport master (
        output enable, flush, req_valid, req_id, fifo_count,
        input  fifo_wen, fifo_wdata, held, drop_count, busy
    );

endinterface

// File: rtl/req_arbiter_rr_pick.sv
// Round-robin priority picker: first set bit of held_i searching from
// rr_ptr_i+1 upwards, modulo NUM_PORTS.
module rr_pick #(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         held_i,
    input  logic [$clog2(NUM_PORTS)-1:0] rr_ptr_i,
    output logic                         grant_valid_o,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx_o
);
    localparam int unsigned PTR_W = $clog2(NUM_PORTS);

    int unsigned idx;

    // Walk offsets from farthest to nearest so the nearest match wins last.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = 0;
        for (int unsigned off = NUM_PORTS; off >= 1; off--) begin
            idx = (32'(rr_ptr_i) + off) % NUM_PORTS;
            if (held_i[idx[PTR_W-1:0]]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/req_arbiter.sv
// Round-robin arbiter merging per-port requester ids into the requestor FIFO
// write port, with one-entry holding registers and FIFO-space throttling.
module req_arbiter
    import req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 5
) (
    input logic         clk,
    input logic         rst,
    req_arbiter_if.slave bus
);
    localparam int unsigned PTR_W   = $clog2(NUM_PORTS);
    localparam int unsigned SPACE_W = CNT_W + 1;

    arb_state_t            state_q, state_d;
    logic [NUM_PORTS-1:0]  held_q, held_d;
    node_id_t              hold_id_q [NUM_PORTS];
    node_id_t              hold_id_d [NUM_PORTS];
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  fifo_wen_q, fifo_wen_d;
    node_id_t              fifo_wdata_q, fifo_wdata_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    logic                  pick_valid;
    logic [PTR_W-1:0]      pick_idx;
    logic [SPACE_W-1:0]    space;
    logic                  grant_en;
    logic [NUM_PORTS-1:0]  capture;
    logic [DROP_CNT_W:0]   drop_sum;

    rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .held_i        (held_q),
        .rr_ptr_i      (rr_ptr_q),
        .grant_valid_o (pick_valid),
        .grant_idx_o   (pick_idx)
    );

    always_comb begin
        // fifo_wen_q covers the write whose count update is not yet visible.
        space    = SPACE_W'(FIFO_DEPTH) - {1'b0, bus.fifo_count} - SPACE_W'(fifo_wen_q);
        grant_en = pick_valid && (state_q != IDLE) && !bus.flush && (space != '0);

        held_d    = held_q;
        hold_id_d = hold_id_q;
        capture   = '0;
        drop_sum  = {1'b0, drop_q};
        if (grant_en) begin
            held_d[pick_idx] = 1'b0;
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (bus.req_valid[i] && !bus.flush) begin
                if (state_q == RUN && (!held_q[i] || (grant_en && pick_idx == PTR_W'(i)))) begin
                    capture[i]   = 1'b1;
                    held_d[i]    = 1'b1;
                    hold_id_d[i] = bus.req_id[i*NODE_ID_W +: NODE_ID_W];
                end else begin
                    drop_sum = drop_sum + 1'b1;
                end
            end
        end
        if (bus.flush) begin
            held_d = '0;
        end
        drop_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];

        fifo_wen_d   = grant_en;
        fifo_wdata_d = grant_en ? hold_id_q[pick_idx] : fifo_wdata_q;
        rr_ptr_d     = grant_en ? pick_idx : rr_ptr_q;

        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enable) state_d = RUN;
            RUN:     if (!bus.enable) state_d = DRAIN;
            DRAIN: begin
                if (bus.enable) begin
                    state_d = RUN;
                end else if (held_q == '0 && !fifo_wen_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            held_q       <= '0;
            hold_id_q    <= '{default: '0};
            rr_ptr_q     <= PTR_W'(NUM_PORTS - 1);
            fifo_wen_q   <= 1'b0;
            fifo_wdata_q <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            hold_id_q    <= hold_id_d;
            rr_ptr_q     <= rr_ptr_d;
            fifo_wen_q   <= fifo_wen_d;
            fifo_wdata_q <= fifo_wdata_d;
            drop_q       <= drop_d;
        end
    end

    assign bus.fifo_wen   = fifo_wen_q;
    assign bus.fifo_wdata = fifo_wdata_q;
    assign bus.held       = held_q;
    assign bus.drop_count = drop_q;
    assign bus.busy       = (state_q != IDLE) || (held_q != '0);

endmodule
